// File: rtl/btb_bimodal_predictor_pkg.sv
// Shared types and helpers for the BTB bimodal branch predictor.
package btb_bimodal_predictor_pkg;

  // Two-bit bimodal confidence states.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  // Tags are held right-aligned in a full word.
  // The unused upper bits stay constant, so the extra storage is free after optimisation.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    cnt_t        cnt;
  } btb_entry_t;

  // A freshly allocated entry starts weakly taken.
  localparam cnt_t BTB_ALLOC_CNT = WT;

  // Advances an event counter by one.
  // With sat set, the counter holds at all-ones instead of wrapping.
  function automatic logic [31:0] bump_event(input logic [31:0] value, input logic sat);
    if (sat && (value == '1)) begin
      return value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/btb_bimodal_predictor_if.sv
// Fetch/execute <-> predictor interface.
// master = fetch/execute side, slave = predictor.
interface btb_bimodal_predictor_if;
  // Lookup request from fetch.
  logic [31:0] current_pc;
  logic        is_branch;
  logic        is_jump;
  logic        is_rv32c;
  logic [12:0] imm_sb;

  // Resolved outcome from execute.
  logic        update_predictor;
  logic [31:0] pc_to_update;
  logic [31:0] update_addr;
  logic        branch_result;
  logic        prediction;
  logic        is_jalr;

  // Predictor answers and performance counters.
  logic        predict_taken;
  logic [31:0] target_addr;
  logic [31:0] predict_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output current_pc, is_branch, is_jump, is_rv32c, imm_sb,
    output update_predictor, pc_to_update, update_addr, branch_result, prediction, is_jalr,
    input  predict_taken, target_addr, predict_cnt, mispredict_cnt
  );

  modport slave (
    input  current_pc, is_branch, is_jump, is_rv32c, imm_sb,
    input  update_predictor, pc_to_update, update_addr, branch_result, prediction, is_jalr,
    output predict_taken, target_addr, predict_cnt, mispredict_cnt
  );
endinterface

// File: rtl/btb_bimodal_predictor_sat_counter2.sv
// Two-bit saturating up/down counter step (combinational).
module sat_counter2
  import btb_bimodal_predictor_pkg::*;
(
  input  cnt_t cnt_in,
  input  logic inc,
  output cnt_t cnt_out
);

  // Step one state toward ST when inc is set, otherwise toward SNT, holding at the ends.
  always_comb begin
    // NOTE: assign a default first so no path through the block leaves cnt_out unassigned, which would infer a latch.
    cnt_out = cnt_in;
    unique case (cnt_in)
      SNT: cnt_out = inc ? WNT : SNT;
      WNT: cnt_out = inc ? WT  : SNT;
      WT:  cnt_out = inc ? ST  : WNT;
      ST:  cnt_out = inc ? ST  : WT;
      default: cnt_out = cnt_in;
    endcase
  end

endmodule

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped BTB with per-entry bimodal counters.
// Lookup is combinational. Training happens on the clock edge.
// The block also keeps prediction and misprediction event counters.
module btb_bimodal_predictor
  import btb_bimodal_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter bit CNT_SAT = 1'b1
) (
  input logic                    CLK,
  input logic                    nRST,
  btb_bimodal_predictor_if.slave bus
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  btb_entry_t btb [ENTRIES];

  // ---------------- lookup ----------------
  logic [IDX_BITS-1:0] lk_idx;
  logic [31:0]         lk_tag;
  btb_entry_t          lk_entry;
  logic                lk_hit;
  logic [31:0]         fall_through;
  logic [31:0]         branch_target;
  logic                pred_taken;
  logic [31:0]         pred_target;

  // Halfword-granular index, so RV32C instructions get their own entries.
  assign lk_idx        = bus.current_pc[IDX_BITS:1];
  assign lk_tag        = 32'(bus.current_pc >> (IDX_BITS + 1));
  assign lk_entry      = btb[lk_idx];
  assign lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign fall_through  = bus.current_pc + (bus.is_rv32c ? 32'd2 : 32'd4);
  assign branch_target = bus.current_pc + {{19{bus.imm_sb[12]}}, bus.imm_sb};

  // Choose the prediction: trained entry, then static BTFN for branches, else fall-through.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = fall_through;
    if (lk_hit) begin
      pred_taken = lk_entry.cnt[1];
      if (lk_entry.cnt[1]) pred_target = lk_entry.target;
    end else if (bus.is_branch) begin
      pred_taken = bus.imm_sb[12];
      if (bus.imm_sb[12]) pred_target = branch_target;
    end
  end

  assign bus.predict_taken = pred_taken;
  assign bus.target_addr   = pred_target;

  // ---------------- update ----------------
  logic [IDX_BITS-1:0] up_idx;
  logic [31:0]         up_tag;
  btb_entry_t          up_entry;
  logic                up_hit;
  logic                up_direct_taken;
  cnt_t                up_cnt_next;

  assign up_idx          = bus.pc_to_update[IDX_BITS:1];
  assign up_tag          = 32'(bus.pc_to_update >> (IDX_BITS + 1));
  assign up_entry        = btb[up_idx];
  assign up_hit          = up_entry.valid && (up_entry.tag == up_tag);
  // JALR targets are register-dependent, so they never supply a target.
  assign up_direct_taken = bus.branch_result && !bus.is_jalr;

  sat_counter2 u_sat (
    .cnt_in  (up_entry.cnt),
    .inc     (bus.branch_result),
    .cnt_out (up_cnt_next)
  );

  // Train the table. A hit moves the counter; a direct taken miss allocates.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: only valid and cnt are reset. Tag and target stay unreset because valid gates every use of them.
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].cnt   <= WNT;
      end
    end else if (bus.update_predictor) begin
      // NOTE: sequential state uses non-blocking assignments, so every reader sees the pre-edge value.
      if (up_hit) begin
        btb[up_idx].cnt <= up_cnt_next;
        if (up_direct_taken) btb[up_idx].target <= bus.update_addr;
      end else if (up_direct_taken) begin
        btb[up_idx] <= '{valid: 1'b1, tag: up_tag, target: bus.update_addr, cnt: BTB_ALLOC_CNT};
      end
    end
  end

  // ---------------- event counters ----------------
  logic [31:0] predict_cnt_q;
  logic [31:0] mispredict_cnt_q;

  // Count every resolved update, and separately those the predictor got wrong.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      predict_cnt_q    <= '0;
      mispredict_cnt_q <= '0;
    end else if (bus.update_predictor) begin
      predict_cnt_q <= bump_event(predict_cnt_q, CNT_SAT);
      if (bus.prediction != bus.branch_result) begin
        mispredict_cnt_q <= bump_event(mispredict_cnt_q, CNT_SAT);
      end
    end
  end

  assign bus.predict_cnt    = predict_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  // Jump pre-decode and the PC byte bit play no part in prediction.
  logic unused_bits;
  assign unused_bits = ^{bus.is_jump, bus.pc_to_update[0]};

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_btb_bimodal_predictor;

  logic CLK;
  logic nRST;

  btb_bimodal_predictor_if bus ();

  btb_bimodal_predictor #(.ENTRIES(16), .CNT_SAT(1'b1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot remembers the full PC that trained it and a confidence level 0..3.
  bit          m_valid [16];
  logic [31:0] m_pc    [16];
  logic [31:0] m_tgt   [16];
  int          m_conf  [16];
  logic [31:0] m_pcnt;
  logic [31:0] m_mcnt;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_conf[i]  = 1;
    end
    m_pcnt = 0;
    m_mcnt = 0;
  endfunction

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 2) % 16);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int s = slot_of(pc);
    return m_valid[s] && ((m_pc[s] / 32) == (pc / 32));
  endfunction

  function automatic void model_lookup(output logic taken, output logic [31:0] tgt);
    logic [31:0] pc   = bus.current_pc;
    logic [31:0] ft   = pc + (bus.is_rv32c ? 2 : 4);
    logic [31:0] offs = {{19{bus.imm_sb[12]}}, bus.imm_sb};
    int s = slot_of(pc);
    taken = 1'b0;
    tgt   = ft;
    if (model_hit(pc)) begin
      taken = (m_conf[s] >= 2);
      if (taken) tgt = m_tgt[s];
    end else if (bus.is_branch && bus.imm_sb[12]) begin
      taken = 1'b1;
      tgt   = pc + offs;
    end
  endfunction

  function automatic void model_update();
    logic [31:0] pc = bus.pc_to_update;
    int s = slot_of(pc);
    bit direct_taken = bus.branch_result && !bus.is_jalr;
    if (model_hit(pc)) begin
      if (bus.branch_result) m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
      else                   m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
      if (direct_taken) m_tgt[s] = bus.update_addr;
    end else if (direct_taken) begin
      m_valid[s] = 1;
      m_pc[s]    = pc;
      m_tgt[s]   = bus.update_addr;
      m_conf[s]  = 2;
    end
    m_pcnt = m_pcnt + 1;
    if (bus.prediction != bus.branch_result) m_mcnt = m_mcnt + 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic lookup(input logic [31:0] pc, input logic br, input logic rvc, input logic [12:0] imm);
    bus.current_pc = pc;
    bus.is_branch  = br;
    bus.is_jump    = 1'b0;
    bus.is_rv32c   = rvc;
    bus.imm_sb     = imm;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] addr, input logic res,
                        input logic pred, input logic jalr);
    bus.update_predictor = 1'b1;
    bus.pc_to_update     = pc;
    bus.update_addr      = addr;
    bus.branch_result    = res;
    bus.prediction       = pred;
    bus.is_jalr          = jalr;
  endtask

  // Direct check of the current outputs against hand-derived constants.
  task automatic probe(input string tag, input logic exp_taken, input logic [31:0] exp_tgt);
    #1;
    check({tag, "_taken"}, 32'(bus.predict_taken), 32'(exp_taken));
    check({tag, "_target"}, bus.target_addr, exp_tgt);
  endtask

  // Compare outputs with the model, clock once, and apply the update to the model.
  task automatic step();
    logic        e_taken;
    logic [31:0] e_tgt;
    #1;
    model_lookup(e_taken, e_tgt);
    check("taken", 32'(bus.predict_taken), 32'(e_taken));
    check("target", bus.target_addr, e_tgt);
    check("pcnt", bus.predict_cnt, m_pcnt);
    check("mcnt", bus.mispredict_cnt, m_mcnt);
    @(posedge CLK);
    if (nRST && bus.update_predictor) model_update();
    @(negedge CLK);
    bus.update_predictor = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [26:0] tag;
    logic [3:0]  idx = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 4))
      0: tag = 27'h0;
      1: tag = 27'h9;
      2: tag = 27'h18;
      3: tag = 27'h7FFFFFF;
      default: tag = 27'($urandom);
    endcase
    return {tag, idx, 1'b0};
  endfunction

  // Watchdog: the bench must always terminate on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    model_reset();
    lookup(32'h0, 1'b0, 1'b0, 13'h0);
    update(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.update_predictor = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Reset state: miss path, fall-through, counters zero.
    lookup(32'h100, 1'b0, 1'b0, 13'h0);
    probe("rst_ft4", 1'b0, 32'h104);
    check("rst_pcnt", bus.predict_cnt, 32'h0);
    check("rst_mcnt", bus.mispredict_cnt, 32'h0);
    lookup(32'h100, 1'b0, 1'b1, 13'h0);
    probe("rst_ft2", 1'b0, 32'h102);

    // Static BTFN on a miss.
    lookup(32'h200, 1'b1, 1'b0, 13'h1FF0);
    probe("btfn_back", 1'b1, 32'h1F0);
    lookup(32'h200, 1'b1, 1'b0, 13'h0010);
    probe("btfn_fwd", 1'b0, 32'h204);
    step();

    // Allocation on a taken miss.
    update(32'h300, 32'h400, 1'b1, 1'b0, 1'b0);
    step();
    lookup(32'h300, 1'b0, 1'b0, 13'h0);
    probe("alloc", 1'b1, 32'h400);
    check("alloc_pcnt", bus.predict_cnt, 32'd1);
    check("alloc_mcnt", bus.mispredict_cnt, 32'd1);

    // Four not-taken updates saturate the counter at strongly not-taken.
    repeat (4) begin
      update(32'h300, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
    end
    probe("sat_low", 1'b0, 32'h304);
    repeat (2) begin
      update(32'h300, 32'h400, 1'b1, 1'b1, 1'b0);
      step();
    end
    probe("retrain", 1'b1, 32'h400);

    // Aliasing: 0x320 shares the index of 0x300 and evicts it.
    update(32'h320, 32'h500, 1'b1, 1'b0, 1'b0);
    step();
    lookup(32'h300, 1'b0, 1'b0, 13'h0);
    probe("evicted", 1'b0, 32'h304);
    lookup(32'h320, 1'b0, 1'b0, 13'h0);
    probe("alias_hit", 1'b1, 32'h500);

    // A JALR taken miss must not allocate.
    update(32'h340, 32'h800, 1'b1, 1'b0, 1'b1);
    step();
    lookup(32'h340, 1'b0, 1'b0, 13'h0);
    probe("jalr_noalloc", 1'b0, 32'h344);
    lookup(32'h320, 1'b0, 1'b0, 13'h0);
    probe("jalr_keep", 1'b1, 32'h500);

    // A same-cycle update and lookup on one index: the lookup sees the old state.
    lookup(32'h360, 1'b0, 1'b0, 13'h0);
    update(32'h360, 32'h900, 1'b1, 1'b0, 1'b0);
    probe("collide_old", 1'b0, 32'h364);
    step();
    probe("collide_new", 1'b1, 32'h900);

    // Asynchronous reset mid-stream. The update on the same edge is dropped.
    update(32'h360, 32'hA00, 1'b1, 1'b1, 1'b0);
    nRST = 1'b0;
    model_reset();
    probe("rst_async", 1'b0, 32'h364);
    step();
    nRST = 1'b1;
    probe("rst_trained_miss", 1'b0, 32'h364);
    check("rst_pcnt2", bus.predict_cnt, 32'h0);
    check("rst_mcnt2", bus.mispredict_cnt, 32'h0);

    // Random traffic against the model, including address wrap near 0xFFFFFFFF.
    for (int n = 0; n < 1500; n++) begin
      lookup(rand_pc(), 1'($urandom), 1'($urandom), {12'($urandom), 1'b0});
      if ($urandom_range(0, 1) == 1) begin
        update(rand_pc(), {$urandom_range(0, 32'hFFFF), 1'b0} , 1'($urandom), 1'($urandom),
               ($urandom_range(0, 5) == 0));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
